// File: rtl/conv11_mac.sv
// conv11_mac: 1x1-conv MAC stage that pulls one pixel per channel, accumulates IN_CH weighted
// products on a bias and hands the sum downstream. Define CONV11_RELU_EN to clamp negative results to 0.
module conv11_mac #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int IN_CH        = 16,
    parameter int CH_W         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    input_ready,
    output logic                    inputbuf_read_en,
    input  logic [DATA_WIDTH-1:0]   in_0_0,
    output logic [CH_W-1:0]         weight_addr,
    input  logic [WEIGHT_WIDTH-1:0] weight_data,
    input  logic [ACC_WIDTH-1:0]    bias,
    output logic [ACC_WIDTH-1:0]    acc_out,
    output logic                    acc_valid,
    input  logic                    acc_ready
);

    localparam int              PROD_W  = DATA_WIDTH + WEIGHT_WIDTH;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(IN_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        MAC,
        OUT
    } state_t;

    state_t                 state, state_nxt;
    logic [CH_W-1:0]        ch, ch_nxt;
    logic [ACC_WIDTH-1:0]   acc, acc_nxt;
    logic [ACC_WIDTH-1:0]   acc_out_nxt;
    logic                   valid_nxt;
    logic                   read_en_nxt;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0]        sum;
    logic [ACC_WIDTH-1:0]        sum_out;

    assign prod     = $signed(in_0_0) * $signed(weight_data);
    assign prod_ext = ACC_WIDTH'(prod);
    // The first channel restarts the sum from the bias instead of the previous frame's total.
    assign sum      = ((ch == '0) ? bias : acc) + prod_ext;

`ifdef CONV11_RELU_EN
    assign sum_out = sum[ACC_WIDTH-1] ? '0 : sum;
`else
    assign sum_out = sum;
`endif

    assign weight_addr = ch;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        acc_nxt     = acc;
        acc_out_nxt = acc_out;
        valid_nxt   = acc_valid;
        read_en_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (input_ready) begin
                    state_nxt   = REQ;
                    read_en_nxt = 1'b1;
                end
            end
            REQ: begin
                state_nxt = MAC;
            end
            MAC: begin
                acc_nxt = sum;
                if (ch == LAST_CH) begin
                    ch_nxt      = '0;
                    state_nxt   = OUT;
                    acc_out_nxt = sum_out;
                    valid_nxt   = 1'b1;
                end else begin
                    ch_nxt    = ch + 1'b1;
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                if (acc_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ch               <= '0;
            acc              <= '0;
            acc_out          <= '0;
            acc_valid        <= 1'b0;
            inputbuf_read_en <= 1'b0;
        end else begin
            state            <= state_nxt;
            ch               <= ch_nxt;
            acc              <= acc_nxt;
            acc_out          <= acc_out_nxt;
            acc_valid        <= valid_nxt;
            inputbuf_read_en <= read_en_nxt;
        end
    end

endmodule

// File: tb/tb_conv11_mac.sv
// Scoreboard bench for conv11_mac: a 4-channel instance driven by a buffer/ROM model, plus a
// 1-channel instance for the single-channel corner cases.
module tb_conv11_mac;

    logic clk;
    logic rst;

    // 4-channel instance
    logic              input_ready;
    logic              inputbuf_read_en;
    logic [7:0]        in_pix;
    logic [1:0]        weight_addr;
    logic [7:0]        weight_data;
    logic [23:0]       bias;
    logic [23:0]       acc_out;
    logic              acc_valid;
    logic              acc_ready;

    // 1-channel instance
    logic              ir1;
    logic              rd1;
    logic [7:0]        in1;
    logic [0:0]        wa1;
    logic [7:0]        w1;
    logic [23:0]       bias1;
    logic [23:0]       out1;
    logic              v1;
    logic              ready1;

    logic signed [7:0] wrom [4];
    logic [7:0]        pix_q [$];
    logic [23:0]       exp_q [$];
    int                rd_cyc [$];
    int                cyc;
    int                valid_cyc;
    logic              valid_q;
    int                checks;
    int                errors;

    conv11_mac #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(24), .IN_CH(4), .CH_W(2)) u_dut (
        .clk(clk), .rst(rst), .input_ready(input_ready), .inputbuf_read_en(inputbuf_read_en),
        .in_0_0(in_pix), .weight_addr(weight_addr), .weight_data(weight_data), .bias(bias),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready)
    );

    conv11_mac #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(24), .IN_CH(1), .CH_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .input_ready(ir1), .inputbuf_read_en(rd1),
        .in_0_0(in1), .weight_addr(wa1), .weight_data(w1), .bias(bias1),
        .acc_out(out1), .acc_valid(v1), .acc_ready(ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign weight_data = wrom[weight_addr];

    // Input buffer model: a read strobe seen at an edge presents the next pixel for the following cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (inputbuf_read_en) begin
            rd_cyc.push_back(cyc);
            if (pix_q.size() > 0) in_pix = pix_q.pop_front();
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && acc_valid && !valid_q) valid_cyc = cyc;
        valid_q = acc_valid;
        if (!rst && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else check("acc_out", acc_out, exp_q.pop_front());
        end
    end

    function automatic logic [23:0] model(input logic signed [7:0] p [4],
                                          input logic signed [7:0] w [4],
                                          input logic signed [23:0] b);
        longint      s;
        logic [23:0] r;
        s = longint'(b);
        for (int i = 0; i < 4; i++) s = s + longint'(p[i]) * longint'(w[i]);
        r = s[23:0];
`ifdef CONV11_RELU_EN
        if (r[23]) r = '0;
`endif
        return r;
    endfunction

    task automatic wait_reads(input int n);
        for (int i = 0; i < 100 && rd_cyc.size() < n; i++) @(posedge clk) #1;
        if (rd_cyc.size() < n) check("read_timeout", rd_cyc.size(), n);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk) #1;
        check("sb_drain", exp_q.size(), 0);
    endtask

    task automatic start_frame(input logic signed [7:0] p [4], input logic signed [7:0] w [4],
                               input logic [23:0] b, input bit keep_ir);
        rd_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            pix_q.push_back(p[i]);
            wrom[i] = w[i];
        end
        bias = b;
        exp_q.push_back(model(p, w, b));
        input_ready = 1'b1;
        wait_reads(4);
        if (!keep_ir) input_ready = 1'b0;
    endtask

    task automatic run_single(input logic [7:0] p, input logic [7:0] w, input logic [23:0] b,
                              input logic [23:0] exp);
        in1 = p; w1 = w; bias1 = b;
        ir1 = 1'b1;
        for (int i = 0; i < 20 && !rd1; i++) @(posedge clk) #1;
        ir1 = 1'b0;
        for (int i = 0; i < 20 && !v1; i++) @(posedge clk) #1;
        @(negedge clk);
        check("single_valid", v1, 1);
        check("single_acc", out1, exp);
        check("single_waddr", wa1, 0);
        @(posedge clk) #1 ready1 = 1'b1;
        @(posedge clk) #1 ready1 = 1'b0;
        @(negedge clk) check("single_release", v1, 0);
    endtask

    initial begin
        logic signed [7:0] pa [4];
        logic signed [7:0] wa [4];
        logic [23:0]       e;
        checks = 0; errors = 0; cyc = 0; valid_cyc = 0; valid_q = 1'b0;
        rst = 1'b1; input_ready = 1'b0; acc_ready = 1'b0; bias = '0; in_pix = '0;
        ir1 = 1'b0; in1 = '0; w1 = '0; bias1 = '0; ready1 = 1'b0;
        for (int i = 0; i < 4; i++) wrom[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", acc_valid, 0);
        check("rst_read_en", inputbuf_read_en, 0);
        check("rst_waddr", weight_addr, 0);
        check("rst_acc_out", acc_out, 0);
        @(posedge clk) #1 rst = 1'b0;

        // Sum with bias, input_ready held high: also measures read spacing and result latency.
        acc_ready = 1'b1;
        pa = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        wa = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        start_frame(pa, wa, 24'd10, 1'b0);
        wait_drain();
        check("reads_frame1", rd_cyc.size(), 4);
        if (rd_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("rd_spacing", rd_cyc[i] - rd_cyc[i-1], 3);
            check("valid_latency", valid_cyc - rd_cyc[3], 1);
        end

        // Negative final sum: clamped or raw depending on build.
        pa = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        wa = '{-8'sd2, -8'sd2, -8'sd2, -8'sd2};
        start_frame(pa, wa, 24'd3, 1'b0);
        wait_drain();

        // Wrap past the positive limit of the accumulator.
        pa = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        wa = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        start_frame(pa, wa, 24'h7FFFFF, 1'b0);
        wait_drain();

        // Backpressure with input_ready still high: result must hold and no reads issued.
        acc_ready = 1'b0;
        pa = '{8'sd5, -8'sd6, 8'sd7, -8'sd8};
        wa = '{8'sd3, -8'sd2, 8'sd1, 8'sd4};
        e = model(pa, wa, 24'd100);
        start_frame(pa, wa, 24'd100, 1'b1);
        for (int i = 0; i < 20 && !acc_valid; i++) @(posedge clk) #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", acc_valid, 1);
            check("bp_acc_out", acc_out, e);
            check("bp_read_en", inputbuf_read_en, 0);
        end
        @(posedge clk) #1;
        acc_ready = 1'b1;
        input_ready = 1'b0;
        @(posedge clk) #1 acc_ready = 1'b0;
        @(negedge clk) check("bp_release", acc_valid, 0);
        check("bp_reads", rd_cyc.size(), 4);
        wait_drain();

        // Reset after two channels, then a clean frame must match frame 1 alone.
        acc_ready = 1'b1;
        rd_cyc.delete();
        for (int i = 0; i < 4; i++) pix_q.push_back(8'd50);
        bias = 24'd1000;
        input_ready = 1'b1;
        wait_reads(2);
        @(posedge clk) #1;
        rst = 1'b1;
        input_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 pix_q.delete();
        @(negedge clk);
        check("midrst_waddr", weight_addr, 0);
        check("midrst_valid", acc_valid, 0);
        @(posedge clk) #1 rst = 1'b0;
        pa = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        wa = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        start_frame(pa, wa, 24'd10, 1'b0);
        wait_drain();
        check("midrst_reads", rd_cyc.size(), 4);

        // Single-channel instance: corner product, then bias plus negative product.
        run_single(8'h80, 8'h80, 24'd0, 24'd16384);
`ifdef CONV11_RELU_EN
        run_single(8'd3, 8'hF9, 24'd5, 24'd0);
`else
        run_single(8'd3, 8'hF9, 24'd5, 24'hFFFFF0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
